dffram_2p_clr: RTL and testbench
================================

Name: dffram_2p_clr

Overview:
- Parametrised successor to the single-port DFFRAM macros.
- Generalises word width and depth.
- Adds a second, read-only port with optional same-address write forwarding.
- Adds a hardware clear sequencer that zeroes the whole array after reset or on request.
- Intended as the storage primitive for register files and small buffers in SoC wrappers that need deterministic contents after reset.

Parameters:
- WSIZE, 4, bytes per word; data width is WSIZE*8, one write-enable bit per byte.
- WORDS, 256, number of words; need not be a power of two, minimum 2.
- AWIDTH, $clog2(WORDS), address width (derived, not overridden).
- FORWARD, 1, 1 = port 1 returns newly written bytes on a same-cycle same-address write; 0 = port 1 returns old data.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN0  in  1  port 0 enable.
- WE0  in  WSIZE  port 0 byte write enables.
- A0  in  AWIDTH  port 0 address.
- Di0  in  WSIZE*8  port 0 write data.
- Do0  out  WSIZE*8  port 0 registered read data.
- EN1  in  1  port 1 (read-only) enable.
- A1  in  AWIDTH  port 1 address.
- Do1  out  WSIZE*8  port 1 registered read data.
- CLR  in  1  clear request, single-cycle pulse.
- BUSY  out  1  clear sweep in progress; both ports are ignored while high.

Behaviour:
- Reset:
  - A posedge with RST=1 sets state CLEAR, ptr=0, Do0=0, Do1=0.
  - BUSY is 1 from the cycle after reset is sampled.
  - The storage array itself is not reset; the sweep zeroes it.
- FSM, states IDLE and CLEAR:
  - CLEAR: each cycle writes all-zero to mem[ptr], then ptr++.
  - On the cycle that writes ptr==WORDS-1, go to IDLE.
  - A sweep therefore takes exactly WORDS cycles after RST deasserts.
  - BUSY = (state==CLEAR), decoded combinationally from the state register.
- IDLE with CLR=1: enter CLEAR with ptr=0 on the next edge. EN0/EN1 in that same cycle are still serviced.
- CLR while BUSY: ignored, no restart.
- RST mid-sweep: sweep restarts from ptr=0.
- Port 0 write (IDLE, EN0=1, WE0!=0):
  - Byte i of mem[A0] takes Di0[8i+7:8i] where WE0[i]=1; other bytes are unchanged.
  - Do0 holds its previous value.
- Port 0 read (IDLE, EN0=1, WE0==0): Do0 <= mem[A0], 1-cycle latency, valid after the next rising edge.
- Port 1 read (IDLE, EN1=1): Do1 <= mem[A1], 1-cycle latency.
- Port 1 on a same-cycle port 0 write with A1==A0:
  - FORWARD=1: Do1 gets the byte-merged new word.
  - FORWARD=0: Do1 gets the pre-write word.
- EN=0 on either port: that port's Do holds.
- BUSY=1: EN0/WE0/EN1 ignored, no array write from the ports, Do0/Do1 hold (0 after reset).
- Address >= WORDS (non-power-of-two depth): write is dropped; read returns 0.

Decomposition:
- Package dffram_pkg holds:
  - constant BYTE_W=8;
  - enum clr_state_t {IDLE, CLEAR};
  - a function for the byte-mask merge (old word, new word, WE) shared by the write path and the forwarding path.
- One sub-module, dffram_clr_seq, holds:
  - the FSM and ptr counter;
  - outputs BUSY, clr_we, clr_addr.
- The top muxes the sweep write over port 0 when BUSY=1.

Test Plan:
- Reset then clear: hold RST 2 cycles, release.
  - BUSY=1 for exactly 256 cycles, then 0.
  - Reading 'h00, 'h7F and 'hFF on both ports returns 32'h0.
- Byte writes: write 'h10=AA0055BB mask 1111, then 'h10=00330000 mask 0100, then read via port 0 -> Do0=AA3355BB one edge after the read is sampled.
- Dual-port concurrency:
  - Setup: 'h20=11223344 already written.
  - Stimulus, same cycle: port 0 writes 'h21=CAFEBABE mask 1111; port 1 reads 'h20.
  - Required: Do1=11223344, Do0 unchanged.
- Forwarding:
  - Setup: 'h30=11223344.
  - Stimulus, same cycle: port 0 writes 'h30=000000FF mask 0001; port 1 reads 'h30.
  - FORWARD=1 -> Do1=112233FF.
  - FORWARD=0 build -> Do1=11223344.
- CLR mid-traffic:
  - Setup: 'hF0=F0F055BB written.
  - Pulse CLR. During the sweep, issue a write 'hF1=12345678 and a CLR pulse.
  - Both are ignored; BUSY lasts 256 cycles.
  - Afterwards 'hF0 and 'hF1 read 0.
- Non-power-of-two and reset mid-sweep (WORDS=200, WSIZE=2):
  - Assert RST at sweep cycle 50 -> BUSY lasts 200 cycles after release.
  - A write to 'hC8 is dropped and a read of 'hC8 returns 16'h0.

Source files
------------

// File: rtl/dffram_pkg.sv
// ---------------------------------------------------------------------------
// dffram_pkg
// Shared definitions for the dffram_2p_clr storage primitive.
//   BYTE_W      : bits per byte lane; one write-enable bit covers one lane.
//   MAX_WSIZE   : widest word (in bytes) that byte_merge can handle.
//   clr_state_t : state encoding of the clear sequencer.
//   byte_merge  : lane-wise merge of a new word into an old word. Both the
//                 array write path and the port-1 forwarding path use it, so
//                 a forwarded word always matches the word that gets stored.
// ---------------------------------------------------------------------------
package dffram_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_WSIZE = 16;
    localparam int MAX_DW    = MAX_WSIZE * BYTE_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Callers zero-extend narrower words and masks into the MAX_DW/MAX_WSIZE
    // containers and truncate the result back to their own width.
    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0]    old_word,
        input logic [MAX_DW-1:0]    new_word,
        input logic [MAX_WSIZE-1:0] we
    );
        logic [MAX_DW-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_WSIZE; i++) begin
            if (we[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dffram_clr_seq.sv
// ---------------------------------------------------------------------------
// dffram_clr_seq
// Clear sequencer: walks a pointer over every word of the array, one word per
// cycle, after reset or on a clear request issued while idle.
// Ports:
//   clk_i      : clock, all state on the rising edge
//   rst_i      : synchronous active-high reset; (re)starts a sweep at word 0
//   clr_i      : clear request pulse, honoured only while idle
//   busy_o     : sweep in progress (decoded from the state register)
//   clr_we_o   : zero-write strobe for the array
//   clr_addr_o : word being zeroed this cycle
// ---------------------------------------------------------------------------
module dffram_clr_seq
    import dffram_pkg::*;
#(
    parameter int WORDS  = 256,
    parameter int AWIDTH = $clog2(WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [AWIDTH-1:0] clr_addr_o
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(WORDS - 1);

    clr_state_t        state_q, state_d;
    logic [AWIDTH-1:0] ptr_q, ptr_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, regardless of process order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                // The cycle that zeroes the last word also leaves the sweep.
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AWIDTH'(1);
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy_o     = (state_q == CLEAR);
    assign clr_we_o   = (state_q == CLEAR);
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/dffram_2p_clr.sv
// ---------------------------------------------------------------------------
// dffram_2p_clr
// Flip-flop RAM with one read/write port (byte enables), one read-only port
// with optional same-address write forwarding, and a hardware clear sweep
// that zeroes the array after reset or on request.
// Ports:
//   CLK  : clock, all state on the rising edge
//   RST  : synchronous active-high reset (starts a clear sweep)
//   EN0  : port 0 enable
//   WE0  : port 0 byte write enables (all zero = read)
//   A0   : port 0 address
//   Di0  : port 0 write data
//   Do0  : port 0 registered read data
//   EN1  : port 1 enable (read only)
//   A1   : port 1 address
//   Do1  : port 1 registered read data
//   CLR  : clear request pulse
//   BUSY : clear sweep in progress; both ports are ignored while high
// AWIDTH is derived from WORDS and must not be overridden.
// WSIZE must not exceed dffram_pkg::MAX_WSIZE.
// ---------------------------------------------------------------------------
module dffram_2p_clr
    import dffram_pkg::*;
#(
    parameter int WSIZE   = 4,
    parameter int WORDS   = 256,
    parameter int AWIDTH  = $clog2(WORDS),
    parameter int FORWARD = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN0,
    input  logic [WSIZE-1:0]          WE0,
    input  logic [AWIDTH-1:0]         A0,
    input  logic [WSIZE*BYTE_W-1:0]   Di0,
    output logic [WSIZE*BYTE_W-1:0]   Do0,
    input  logic                      EN1,
    input  logic [AWIDTH-1:0]         A1,
    output logic [WSIZE*BYTE_W-1:0]   Do1,
    input  logic                      CLR,
    output logic                      BUSY
);

    localparam int DW = WSIZE * BYTE_W;

    // NOTE: the storage array has no reset; deterministic contents come from
    // the clear sweep, which keeps the array free of per-bit reset logic.
    logic [DW-1:0] mem_q [WORDS];

    logic              busy;
    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;

    logic          in_rng0, in_rng1;
    logic          port_wr, fwd1;
    logic [DW-1:0] rd_word0, rd_word1, merged0;
    logic [DW-1:0] do0_q, do0_d, do1_q, do1_d;

    dffram_clr_seq #(
        .WORDS  (WORDS),
        .AWIDTH (AWIDTH)
    ) u_clr_seq (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clr_i      (CLR),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    always_comb begin
        // Addresses past the last word exist only for non-power-of-two depths:
        // they read as zero and never write.
        in_rng0 = ({1'b0, A0} < (AWIDTH+1)'(WORDS));
        in_rng1 = ({1'b0, A1} < (AWIDTH+1)'(WORDS));

        rd_word0 = '0;
        rd_word1 = '0;
        if (in_rng0) rd_word0 = mem_q[A0];
        if (in_rng1) rd_word1 = mem_q[A1];

        merged0 = DW'(byte_merge(MAX_DW'(rd_word0), MAX_DW'(Di0), MAX_WSIZE'(WE0)));
        port_wr = !busy && EN0 && (WE0 != '0) && in_rng0;
        fwd1    = (FORWARD != 0) && port_wr && (A1 == A0);

        // Read registers hold unless their port performs a read; a port-0
        // write leaves Do0 untouched.
        do0_d = do0_q;
        do1_d = do1_q;
        if (!busy) begin
            if (EN0 && (WE0 == '0)) do0_d = rd_word0;
            if (EN1)                do1_d = fwd1 ? merged0 : rd_word1;
        end
    end

    // The sweep owns the single write port while it runs.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (port_wr) begin
            mem_q[A0] <= merged0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            do0_q <= '0;
            do1_q <= '0;
        end else begin
            do0_q <= do0_d;
            do1_q <= do1_d;
        end
    end

    assign Do0  = do0_q;
    assign Do1  = do1_q;
    assign BUSY = busy;

endmodule

// File: tb/tb_dffram_2p_clr.sv
// ---------------------------------------------------------------------------
// tb_dffram_2p_clr
// Three instances share one clock:
//   dut    : default build (WSIZE=4, WORDS=256, FORWARD=1)
//   dut_nf : same inputs as dut, FORWARD=0
//   dut_np : WSIZE=2, WORDS=200 (non-power-of-two depth)
// Drivers push the expected registered output of each issued cycle into a
// scoreboard queue; a monitor compares it on the falling edge after the
// rising edge that produced it.
// Streams: 0=dut.Do0 1=dut.Do1 2=dut_nf.Do1 3=dut_np.Do0 4=dut_np.Do1
// ---------------------------------------------------------------------------
module tb_dffram_2p_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut / dut_nf stimulus
    logic        rst, en0, en1, clr;
    logic [3:0]  we0;
    logic [7:0]  a0, a1;
    logic [31:0] di0;
    logic [31:0] do0, do1, do0_nf, do1_nf;
    logic        busy, busy_nf;

    // dut_np stimulus
    logic        rst_np, en0_np, en1_np, clr_np;
    logic [1:0]  we0_np;
    logic [7:0]  a0_np, a1_np;
    logic [15:0] di0_np, do0_np, do1_np;
    logic        busy_np;

    dffram_2p_clr dut (
        .CLK(clk), .RST(rst), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0), .Do0(do0),
        .EN1(en1), .A1(a1), .Do1(do1), .CLR(clr), .BUSY(busy)
    );

    dffram_2p_clr #(.FORWARD(0)) dut_nf (
        .CLK(clk), .RST(rst), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0), .Do0(do0_nf),
        .EN1(en1), .A1(a1), .Do1(do1_nf), .CLR(clr), .BUSY(busy_nf)
    );

    dffram_2p_clr #(.WSIZE(2), .WORDS(200)) dut_np (
        .CLK(clk), .RST(rst_np), .EN0(en0_np), .WE0(we0_np), .A0(a0_np), .Di0(di0_np), .Do0(do0_np),
        .EN1(en1_np), .A1(a1_np), .Do1(do1_np), .CLR(clr_np), .BUSY(busy_np)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          stream;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] tag = '0;
    logic [4:0] due = '0;

    task automatic exp_push(input int s, input logic [31:0] v, input string nm);
        exp_t e;
        e.stream = s;
        e.val    = v;
        e.name   = nm;
        sb.push_back(e);
        tag[s] = 1'b1;
    endtask

    function automatic logic [31:0] stream_val(input int k);
        case (k)
            0:       return do0;
            1:       return do1;
            2:       return do1_nf;
            3:       return {16'h0, do0_np};
            4:       return {16'h0, do1_np};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) due <= tag;

    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (due[k]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: stream %0d has no expectation", k);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.stream != k) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_order: got stream %0d, want stream %0d (%s)", k, e.stream, e.name);
                    end else begin
                        check(e.name, stream_val(k), e.val);
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic op(input logic e0, input logic [3:0] w0, input logic [7:0] ad0,
                      input logic [31:0] d0, input logic e1, input logic [7:0] ad1,
                      input logic c);
        @(negedge clk);
        tag = '0;
        en0 = e0; we0 = w0; a0 = ad0; di0 = d0; en1 = e1; a1 = ad1; clr = c;
        en0_np = 1'b0; we0_np = '0; en1_np = 1'b0; clr_np = 1'b0;
    endtask

    task automatic np_op(input logic e0, input logic [1:0] w0, input logic [7:0] ad0,
                         input logic [15:0] d0, input logic e1, input logic [7:0] ad1);
        @(negedge clk);
        tag = '0;
        en0 = 1'b0; we0 = '0; en1 = 1'b0; clr = 1'b0;
        en0_np = e0; we0_np = w0; a0_np = ad0; di0_np = d0; en1_np = e1; a1_np = ad1;
    endtask

    task automatic idle_cycle();
        op(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0);
    endtask

    // Adds one per falling edge on which BUSY is still high; bounded.
    task automatic count_busy(input bit use_np, inout int n);
        for (int i = 0; i < 2000; i++) begin
            idle_cycle();
            if (use_np ? busy_np : busy) n++;
            else break;
        end
    endtask

    int n;

    initial begin
        rst = 1'b1; en0 = 1'b0; we0 = '0; a0 = '0; di0 = '0; en1 = 1'b0; a1 = '0; clr = 1'b0;
        rst_np = 1'b1; en0_np = 1'b0; we0_np = '0; a0_np = '0; di0_np = '0;
        en1_np = 1'b0; a1_np = '0; clr_np = 1'b0;

        // ---- reset then clear ----
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_do0", do0, 32'h0);
        check("rst_do1", do1, 32'h0);
        check("rst_busy_nf", 32'(busy_nf), 32'h1);
        check("rst_do0_nf", do0_nf, 32'h0);
        rst = 1'b0;
        n = busy ? 1 : 0;
        count_busy(1'b0, n);
        check("reset_sweep_len", 32'(n), 32'd256);

        op(1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h7F, 1'b0);
        exp_push(0, 32'h0, "clr_rd0_00"); exp_push(1, 32'h0, "clr_rd1_7f");
        op(1'b1, 4'h0, 8'h7F, 32'h0, 1'b1, 8'hFF, 1'b0);
        exp_push(0, 32'h0, "clr_rd0_7f"); exp_push(1, 32'h0, "clr_rd1_ff");
        op(1'b1, 4'h0, 8'hFF, 32'h0, 1'b1, 8'h00, 1'b0);
        exp_push(0, 32'h0, "clr_rd0_ff"); exp_push(1, 32'h0, "clr_rd1_00");

        // ---- byte writes ----
        op(1'b1, 4'hF, 8'h10, 32'hAA0055BB, 1'b0, 8'h00, 1'b0);
        exp_push(0, 32'h0, "wr_hold_do0_a");
        op(1'b1, 4'h4, 8'h10, 32'h00330000, 1'b0, 8'h00, 1'b0);
        exp_push(0, 32'h0, "wr_hold_do0_b");
        op(1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h00, 1'b0);
        exp_push(0, 32'hAA3355BB, "byte_merge_rd");

        // ---- dual-port concurrency ----
        op(1'b1, 4'hF, 8'h20, 32'h11223344, 1'b0, 8'h00, 1'b0);
        exp_push(0, 32'hAA3355BB, "dp_setup_hold");
        op(1'b1, 4'hF, 8'h21, 32'hCAFEBABE, 1'b1, 8'h20, 1'b0);
        exp_push(0, 32'hAA3355BB, "dp_do0_unchanged");
        exp_push(1, 32'h11223344, "dp_do1");
        exp_push(2, 32'h11223344, "dp_do1_nf");
        op(1'b1, 4'h0, 8'h21, 32'h0, 1'b0, 8'h00, 1'b0);
        exp_push(0, 32'hCAFEBABE, "dp_wr_landed");

        // ---- forwarding ----
        op(1'b1, 4'hF, 8'h30, 32'h11223344, 1'b0, 8'h00, 1'b0);
        exp_push(0, 32'hCAFEBABE, "fwd_setup_hold");
        op(1'b1, 4'h1, 8'h30, 32'h000000FF, 1'b1, 8'h30, 1'b0);
        exp_push(0, 32'hCAFEBABE, "fwd_do0_hold");
        exp_push(1, 32'h112233FF, "fwd_do1");
        exp_push(2, 32'h11223344, "nofwd_do1");
        op(1'b1, 4'h0, 8'h30, 32'h0, 1'b1, 8'h30, 1'b0);
        exp_push(0, 32'h112233FF, "fwd_after_do0");
        exp_push(1, 32'h112233FF, "fwd_after_do1");
        exp_push(2, 32'h112233FF, "nofwd_after_do1");

        // ---- enables low: no write, outputs hold ----
        op(1'b0, 4'hF, 8'h30, 32'hDEADBEEF, 1'b0, 8'h10, 1'b0);
        exp_push(0, 32'h112233FF, "en0_low_hold");
        exp_push(1, 32'h112233FF, "en1_low_hold");
        op(1'b1, 4'h0, 8'h30, 32'h0, 1'b0, 8'h00, 1'b0);
        exp_push(0, 32'h112233FF, "en0_low_no_write");

        // ---- CLR mid-traffic ----
        op(1'b1, 4'hF, 8'hF0, 32'hF0F055BB, 1'b0, 8'h00, 1'b0);
        exp_push(0, 32'h112233FF, "clr_setup_hold");
        op(1'b1, 4'h0, 8'hF0, 32'h0, 1'b0, 8'h00, 1'b0);
        exp_push(0, 32'hF0F055BB, "clr_setup_rd");
        op(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'hF0, 1'b1);
        exp_push(1, 32'hF0F055BB, "clr_cycle_rd1");
        op(1'b1, 4'hF, 8'hF1, 32'h12345678, 1'b1, 8'h00, 1'b0);
        exp_push(0, 32'hF0F055BB, "busy_wr_do0_hold");
        exp_push(1, 32'hF0F055BB, "busy_rd1_ignored");
        n = busy ? 1 : 0;
        op(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b1);
        exp_push(0, 32'hF0F055BB, "busy_rd0_ignored");
        if (busy) n++;
        count_busy(1'b0, n);
        check("clr_sweep_len", 32'(n), 32'd256);
        op(1'b1, 4'h0, 8'hF0, 32'h0, 1'b1, 8'hF1, 1'b0);
        exp_push(0, 32'h0, "cleared_f0");
        exp_push(1, 32'h0, "busy_write_dropped_f1");

        // ---- non-power-of-two depth, reset mid-sweep ----
        idle_cycle();
        rst_np = 1'b0;
        check("np_rst_busy", 32'(busy_np), 32'h1);
        check("np_rst_do0", {16'h0, do0_np}, 32'h0);
        repeat (50) idle_cycle();
        rst_np = 1'b1;
        idle_cycle();
        rst_np = 1'b0;
        n = busy_np ? 1 : 0;
        count_busy(1'b1, n);
        check("np_sweep_len", 32'(n), 32'd200);

        np_op(1'b1, 2'b11, 8'hC7, 16'h1234, 1'b0, 8'h00);
        exp_push(3, 32'h0, "np_wr_hold_a");
        np_op(1'b1, 2'b11, 8'hC8, 16'hBEEF, 1'b0, 8'h00);
        exp_push(3, 32'h0, "np_wr_hold_b");
        np_op(1'b1, 2'b00, 8'hC7, 16'h0, 1'b1, 8'hC7);
        exp_push(3, 32'h1234, "np_rd0_c7");
        exp_push(4, 32'h1234, "np_rd1_c7");
        np_op(1'b1, 2'b00, 8'hC8, 16'h0, 1'b1, 8'hC8);
        exp_push(3, 32'h0, "np_rd0_c8_oor");
        exp_push(4, 32'h0, "np_rd1_c8_oor");
        np_op(1'b1, 2'b00, 8'h00, 16'h0, 1'b1, 8'hC7);
        exp_push(3, 32'h0, "np_no_alias_00");
        exp_push(4, 32'h1234, "np_rd1_c7_again");

        idle_cycle();
        idle_cycle();
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
